// File: rtl/branch_train_queue.sv
// branch_train_queue: circular queue of in-flight dual-issue branch predictions.
// Fetch pushes {PC, predicted target}, execute pops in program order, and the
// popped entries are resolved into predictor training and a redirect/flush on
// a mispredict.
module branch_train_queue #(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_valid0,
    input  logic          pred_valid1,
    input  logic [31:0]   pred_pc0,
    input  logic [31:0]   pred_pc1,
    input  logic [31:0]   pred_target0,
    input  logic [31:0]   pred_target1,
    output logic          queue_ready,
    input  logic          res_valid0,
    input  logic          res_valid1,
    input  logic          res_isbranch0,
    input  logic          res_isbranch1,
    input  logic          res_taken0,
    input  logic          res_taken1,
    input  logic [31:0]   res_target0,
    input  logic [31:0]   res_target1,
    output logic          train_valid0,
    output logic          train_valid1,
    output logic          isbranch0,
    output logic          isbranch1,
    output logic [31:0]   address_branch0,
    output logic [31:0]   address_branch1,
    output logic [31:0]   address_result0,
    output logic [31:0]   address_result1,
    output logic          taken0,
    output logic          taken1,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc,
    output logic [PW:0]   count,
    output logic          underflow
);

    logic [31:0] r_pc  [DEPTH];
    logic [31:0] r_tgt [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_underflow;

    logic [PW-1:0] w_head1;
    logic [PW-1:0] w_tail1;
    logic          w_pop0;
    logic          w_pop1;
    logic          w_short;
    logic [31:0]   w_pc0;
    logic [31:0]   w_pc1;
    logic [31:0]   w_act0;
    logic [31:0]   w_act1;
    logic          w_mis0;
    logic          w_mis1;
    logic          w_flush;
    logic          w_enq0;
    logic          w_enq1;
    logic [PW:0]   w_nenq;
    logic [PW:0]   w_npop;

    assign queue_ready = (r_count <= (PW+1)'(DEPTH - 2));
    assign count       = r_count;
    assign underflow   = r_underflow;

    // Pop/enqueue decode and resolve of the two oldest entries.
    always_comb begin
        w_head1 = r_head + PW'(1);
        w_tail1 = r_tail + PW'(1);
        // Slot 1 of the resolve only counts behind a slot 0 resolve.
        w_pop0  = res_valid0 && (r_count >= (PW+1)'(1));
        w_pop1  = res_valid0 && res_valid1 && (r_count >= (PW+1)'(2));
        w_short = (res_valid0 && !w_pop0) || (res_valid0 && res_valid1 && !w_pop1);
        w_pc0   = r_pc[r_head];
        w_pc1   = r_pc[w_head1];
        w_act0  = res_taken0 ? res_target0 : w_pc0 + 32'd4;
        w_act1  = res_taken1 ? res_target1 : w_pc1 + 32'd4;
        w_mis0  = w_pop0 && (w_act0 != r_tgt[r_head]);
        // A slot 0 mispredict squashes slot 1 entirely.
        w_mis1  = w_pop1 && !w_mis0 && (w_act1 != r_tgt[w_head1]);
        w_flush = w_mis0 || w_mis1;
        w_enq0  = pred_valid0 && queue_ready && !w_flush;
        w_enq1  = w_enq0 && pred_valid1;
        w_nenq  = (PW+1)'(w_enq0) + (PW+1)'(w_enq1);
        w_npop  = (PW+1)'(w_pop0) + (PW+1)'(w_pop1);
    end

    // Queue storage; contents need no reset since head/tail/count gate them.
    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_pc[r_tail]  <= pred_pc0;
            r_tgt[r_tail] <= pred_target0;
        end
        if (w_enq1) begin
            r_pc[w_tail1]  <= pred_pc1;
            r_tgt[w_tail1] <= pred_target1;
        end
    end

    // Pointers, occupancy and sticky underflow; a flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_short)
                r_underflow <= 1'b1;
            if (w_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                r_head  <= r_head + w_npop[PW-1:0];
                r_tail  <= r_tail + w_nenq[PW-1:0];
                r_count <= r_count + w_nenq - w_npop;
            end
        end
    end

    // Registered training and redirect strobes, one cycle after the resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            train_valid0    <= 1'b0;
            train_valid1    <= 1'b0;
            isbranch0       <= 1'b0;
            isbranch1       <= 1'b0;
            address_branch0 <= '0;
            address_branch1 <= '0;
            address_result0 <= '0;
            address_result1 <= '0;
            taken0          <= 1'b0;
            taken1          <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            train_valid0    <= w_pop0;
            train_valid1    <= w_pop1 && !w_mis0;
            isbranch0       <= w_pop0 && res_isbranch0;
            isbranch1       <= w_pop1 && !w_mis0 && res_isbranch1;
            address_branch0 <= w_pop0 ? w_pc0 : '0;
            address_branch1 <= (w_pop1 && !w_mis0) ? w_pc1 : '0;
            address_result0 <= w_pop0 ? w_act0 : '0;
            address_result1 <= (w_pop1 && !w_mis0) ? w_act1 : '0;
            taken0          <= w_pop0 && res_taken0 && res_isbranch0;
            taken1          <= w_pop1 && !w_mis0 && res_taken1 && res_isbranch1;
            redirect_valid  <= w_flush;
            redirect_pc     <= w_mis0 ? w_act0 : (w_mis1 ? w_act1 : '0);
        end
    end

endmodule

// File: tb/tb_branch_train_queue.sv
// Directed bench for branch_train_queue with hand-computed expectations.
module tb_branch_train_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid0, pred_valid1;
    logic [31:0] pred_pc0, pred_pc1, pred_target0, pred_target1;
    logic        queue_ready;
    logic        res_valid0, res_valid1, res_isbranch0, res_isbranch1;
    logic        res_taken0, res_taken1;
    logic [31:0] res_target0, res_target1;
    logic        train_valid0, train_valid1, isbranch0, isbranch1;
    logic [31:0] address_branch0, address_branch1, address_result0, address_result1;
    logic        taken0, taken1, redirect_valid;
    logic [31:0] redirect_pc;
    logic [PW:0] count;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    branch_train_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .rst(rst),
        .pred_valid0(pred_valid0), .pred_valid1(pred_valid1),
        .pred_pc0(pred_pc0), .pred_pc1(pred_pc1),
        .pred_target0(pred_target0), .pred_target1(pred_target1),
        .queue_ready(queue_ready),
        .res_valid0(res_valid0), .res_valid1(res_valid1),
        .res_isbranch0(res_isbranch0), .res_isbranch1(res_isbranch1),
        .res_taken0(res_taken0), .res_taken1(res_taken1),
        .res_target0(res_target0), .res_target1(res_target1),
        .train_valid0(train_valid0), .train_valid1(train_valid1),
        .isbranch0(isbranch0), .isbranch1(isbranch1),
        .address_branch0(address_branch0), .address_branch1(address_branch1),
        .address_result0(address_result0), .address_result1(address_result1),
        .taken0(taken0), .taken1(taken1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        pred_valid0 = 0; pred_valid1 = 0;
        pred_pc0 = 0; pred_pc1 = 0; pred_target0 = 0; pred_target1 = 0;
        res_valid0 = 0; res_valid1 = 0; res_isbranch0 = 0; res_isbranch1 = 0;
        res_taken0 = 0; res_taken1 = 0; res_target0 = 0; res_target1 = 0;
    endtask

    // Advance one edge; outputs are sampled 1ns after it, inputs then cleared.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic v0, input logic [31:0] pc0, input logic [31:0] t0,
                       input logic v1, input logic [31:0] pc1, input logic [31:0] t1);
        pred_valid0 = v0; pred_pc0 = pc0; pred_target0 = t0;
        pred_valid1 = v1; pred_pc1 = pc1; pred_target1 = t1;
    endtask

    task automatic res0(input logic br, input logic tk, input logic [31:0] tg);
        res_valid0 = 1; res_isbranch0 = br; res_taken0 = tk; res_target0 = tg;
    endtask

    task automatic res1(input logic br, input logic tk, input logic [31:0] tg);
        res_valid1 = 1; res_isbranch1 = br; res_taken1 = tk; res_target1 = tg;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(queue_ready), 1);
        chk("rst_tv0", 32'(train_valid0), 0);
        chk("rst_redir", 32'(redirect_valid), 0);
        chk("rst_uflow", 32'(underflow), 0);

        // Two correct not-taken non-branches.
        enq(1, 32'h100, 32'h104, 1, 32'h104, 32'h108);
        tick(); idle();
        chk("t1_count2", 32'(count), 2);
        res0(0, 0, 0); res1(0, 0, 0);
        tick(); idle();
        chk("t1_tv0", 32'(train_valid0), 1);
        chk("t1_tv1", 32'(train_valid1), 1);
        chk("t1_ab0", address_branch0, 32'h100);
        chk("t1_ar0", address_result0, 32'h104);
        chk("t1_ar1", address_result1, 32'h108);
        chk("t1_redir", 32'(redirect_valid), 0);
        chk("t1_count0", 32'(count), 0);
        tick();
        chk("t1_tv0_pulse", 32'(train_valid0), 0);

        // Slot 0 taken branch mispredicts.
        enq(1, 32'h200, 32'h204, 0, 0, 0);
        tick(); idle();
        res0(1, 1, 32'h400);
        tick(); idle();
        chk("t2_redir", 32'(redirect_valid), 1);
        chk("t2_rpc", redirect_pc, 32'h400);
        chk("t2_taken0", 32'(taken0), 1);
        chk("t2_isbr0", 32'(isbranch0), 1);
        chk("t2_tv1", 32'(train_valid1), 0);
        chk("t2_count", 32'(count), 0);

        // Slot 1 mispredicts; concurrent enqueue is dropped.
        enq(1, 32'h300, 32'h304, 1, 32'h304, 32'h308);
        tick(); idle();
        res0(0, 0, 0); res1(1, 1, 32'h800);
        enq(1, 32'h900, 32'h904, 0, 0, 0);
        tick(); idle();
        chk("t3_tv0", 32'(train_valid0), 1);
        chk("t3_tv1", 32'(train_valid1), 1);
        chk("t3_ar1", address_result1, 32'h800);
        chk("t3_taken1", 32'(taken1), 1);
        chk("t3_redir", 32'(redirect_valid), 1);
        chk("t3_rpc", redirect_pc, 32'h800);
        chk("t3_count", 32'(count), 0);
        chk("t3_ready", 32'(queue_ready), 1);

        // Fill to DEPTH-1, overflow enqueue dropped, then pop and pop+enqueue.
        for (int k = 0; k < 3; k++) begin
            enq(1, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k),
                1, 32'h1004 + 32'(8*k), 32'h1008 + 32'(8*k));
            tick(); idle();
        end
        chk("t4_count6", 32'(count), 6);
        chk("t4_ready6", 32'(queue_ready), 1);
        enq(1, 32'h1018, 32'h101C, 0, 0, 0);
        tick(); idle();
        chk("t4_count7", 32'(count), 7);
        chk("t4_ready7", 32'(queue_ready), 0);
        enq(1, 32'h5000, 32'h5004, 1, 32'h5004, 32'h5008);
        tick(); idle();
        chk("t4_full_drop", 32'(count), 7);
        res0(0, 0, 0);
        tick(); idle();
        chk("t4_pop_ab0", address_branch0, 32'h1000);
        chk("t4_pop_count", 32'(count), 6);
        res0(0, 0, 0);
        enq(1, 32'h101C, 32'h1020, 0, 0, 0);
        tick(); idle();
        chk("t4_popenq_ab0", address_branch0, 32'h1004);
        chk("t4_popenq_count", 32'(count), 6);
        chk("t4_popenq_redir", 32'(redirect_valid), 0);

        // Pointer wrap over 3*DEPTH single enqueue/resolve pairs.
        rst = 1; tick(); rst = 0;
        chk("t5_rst_count", 32'(count), 0);
        for (int i = 0; i < 3*DEPTH; i++) begin
            enq(1, 32'h2000 + 32'(8*i), 32'h2004 + 32'(8*i), 0, 0, 0);
            tick(); idle();
            res0(0, 0, 0);
            tick(); idle();
            chk("t5_tv0", 32'(train_valid0), 1);
            chk("t5_ab0", address_branch0, 32'h2000 + 32'(8*i));
            chk("t5_redir", 32'(redirect_valid), 0);
        end
        chk("t5_count", 32'(count), 0);
        chk("t5_uflow", 32'(underflow), 0);

        // Resolve on empty queue.
        res0(0, 0, 0);
        tick(); idle();
        chk("t6_tv0", 32'(train_valid0), 0);
        chk("t6_uflow", 32'(underflow), 1);
        chk("t6_count", 32'(count), 0);
        tick(); tick();
        chk("t6_uflow_held", 32'(underflow), 1);
        rst = 1; tick(); rst = 0;
        chk("t6_uflow_rst", 32'(underflow), 0);
        chk("t6_ready_rst", 32'(queue_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/branch_train_queue.md
# branch_train_queue

Tracks in-flight dual-issue branch predictions between fetch and execute. Resolves each one against the actual outcome, and drives the training ports of `module_branchprediction` (`train_valid*`, `isbranch*`, `address_branch*`, `address_result*`, `taken*`). It holds the PC and predicted target of every fetched slot in a circular queue. At execute it pops entries in program order, computes the real next address, and raises a redirect plus a full queue flush on a mispredict.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, at least 4.
- `PW`, log2(`DEPTH`): pointer width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pred_valid0`, `pred_valid1`  in  1  fetch slot carries an instruction; slot 0 is older.
- `pred_pc0`, `pred_pc1`  in  32  fetch PCs.
- `pred_target0`, `pred_target1`  in  32  predictor `target0`/`target1` for those PCs.
- `queue_ready`  out  1  at least two free entries.
- `res_valid0`, `res_valid1`  in  1  execute retires the oldest one or two queue entries in order.
- `res_isbranch0`, `res_isbranch1`  in  1  resolved instruction is a branch.
- `res_taken0`, `res_taken1`  in  1  branch actually taken.
- `res_target0`, `res_target1`  in  32  actual branch target, meaningful when taken.
- `train_valid0`, `train_valid1`  out  1  training strobe to the predictor.
- `isbranch0`, `isbranch1`  out  1  training: instruction is a branch.
- `address_branch0`, `address_branch1`  out  32  training: instruction PC.
- `address_result0`, `address_result1`  out  32  training: actual next address.
- `taken0`, `taken1`  out  1  training: branch taken.
- `redirect_valid`  out  1  mispredict; fetch restarts at `redirect_pc`.
- `redirect_pc`  out  32  correct next address.
- `count`  out  `PW`+1  occupied entries.
- `underflow`  out  1  sticky: a resolve arrived with no matching entry.

## Operation
Enqueue:
- Requires `queue_ready` = (`count` <= `DEPTH`-2).
- If `pred_valid0`, write {`pred_pc0`, `pred_target0`} at tail.
- If `pred_valid1` is also set, write slot 1 at tail+1.
- `pred_valid1` without `pred_valid0` is ignored.
- Enqueue while `queue_ready`=0 is dropped; the queue is unchanged.

Resolve:
- `res_valid0` pops head.
- `res_valid1` pops head+1, and only counts when `res_valid0` is also set.
- Actual next address: `actual_i` = `res_taken_i` ? `res_target_i` : entry PC + 4 (modulo 2^32).
- Mispredict when `actual_i` != the stored predicted target.
- Non-branches use the same rule, so a stale taken prediction on a non-branch also mispredicts.

Training (registered):
- `train_valid_i` = popped slot i.
- `isbranch_i` = `res_isbranch_i`.
- `address_branch_i` = stored PC.
- `address_result_i` = `actual_i`.
- `taken_i` = `res_taken_i` & `res_isbranch_i`.

Mispredict:
- Slot 0 mispredicts: slot 1 is squashed (`train_valid1`=0), redirect to `actual0`, and the whole queue is flushed (head=tail, `count`=0).
- Only slot 1 mispredicts: both slots train, redirect to `actual1`, flush.
- An enqueue in the same cycle as a flush is dropped.

Count and pointers:
- Without a flush, `count` changes by (enqueued − popped) in the same cycle.
- Pointers wrap modulo `DEPTH`.

Underflow:
- A resolve that needs more entries than `count` pops nothing for the missing slots and sets `underflow`.
- `underflow` clears only on `rst`.

## Timing
- Reset:
  - All outputs are 0, except `queue_ready`=1.
  - Head, tail and `count` are 0, and `underflow` is 0.
  - Reset asserted mid-operation discards all entries at that edge.
- Latency:
  - Enqueue is visible in `count`/`queue_ready` one cycle later.
  - Training and redirect outputs are valid exactly one cycle after `res_valid*`.
- Strobes: `train_valid*` and `redirect_valid` are single-cycle pulses with no backpressure. The predictor must accept training every cycle.
- `queue_ready` is decoded from the registered `count`, not from inputs.
- After a flush, new enqueues are accepted from the next cycle.

## Test plan
- Reset, then enqueue {0x100, tgt 0x104}, {0x104, tgt 0x108}; resolve both not-taken non-branch -> next cycle `train_valid0`=`train_valid1`=1, `address_result0`=0x104, `address_result1`=0x108, `redirect_valid`=0, `count`=0.
- Enqueue {0x200, tgt 0x204}; resolve with `res_isbranch0`=1, `res_taken0`=1, `res_target0`=0x400 -> `redirect_valid`=1, `redirect_pc`=0x400, `taken0`=1, `count`=0.
- Enqueue two entries, slot 0 correct and slot 1 wrong (taken to 0x800) -> both train, `redirect_pc`=0x800, flush; an enqueue in the same cycle is dropped, so `count`=0.
- Fill to `DEPTH`-1 -> `queue_ready`=0; a further enqueue is ignored; one pop with one enqueue in the same cycle -> `count` unchanged.
- Run 3×`DEPTH` enqueue/resolve pairs -> correct PCs across pointer wrap, no `underflow`.
- `res_valid0` on an empty queue -> `train_valid0`=0, `underflow`=1 and held until `rst`.
